// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_e : receiver FSM encodings (ST_PARITY is only reachable when the
//             design is built with SIPO_PARITY_CHECK_EN defined)
//   dir_e   : shift direction latched at the first bit of every word
//   parity_mismatch() : even-parity check helper
// -----------------------------------------------------------------------------
package sipo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   // LSB-first shifts right (first bit ends in bit 0); MSB-first shifts left
   // (first bit ends in bit WIDTH-1).
   typedef enum logic {
      DIR_LSB_FIRST = 1'b0,
      DIR_MSB_FIRST = 1'b1
   } dir_e;

   // Even parity: data ones plus the parity bit must be an even count.
   // data_xor is the XOR-reduction of the received data word.
   function automatic logic parity_mismatch(input logic data_xor, input logic pbit);
      return data_xor ^ pbit;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_shift_core
// Shift register, bit counter and per-word direction latch of the deserializer.
// The owning FSM decides when bits are accepted; this block only shifts.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   sen    in   1      shift enable: shift sdata in using the latched direction
//   sdata  in   1      serial data bit
//   start  in   1      first bit of a new word: restart shreg/cnt, latch dir
//   dir    in   1      direction for the word being started (1 = MSB first)
//   word   out  WIDTH  shift register contents *after* this cycle's bit, so
//                      the owner can capture a completed word in the same cycle
//   cnt    out  CNT_W  bits received so far in the current word (registered)
// -----------------------------------------------------------------------------
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sen,
   input  logic             sdata,
   input  logic             start,
   input  logic             dir,
   output logic [WIDTH-1:0] word,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   dir_e             dir_q,   dir_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;

      if (start) begin
         // A new word discards whatever was partially collected; the first
         // bit lands at the end it will occupy once the word is complete
         // after the remaining WIDTH-1 shifts.
         dir_d = dir_e'(dir);
         cnt_d = CNT_W'(1);
         if (dir_e'(dir) == DIR_MSB_FIRST) begin
            shreg_d = {{(WIDTH-1){1'b0}}, sdata};
         end else begin
            shreg_d = {sdata, {(WIDTH-1){1'b0}}};
         end
      end else if (sen) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (dir_q == DIR_MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdata};
         end else begin
            shreg_d = {sdata, shreg_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the shift register is a handful of flops, not a RAM, so it
         // is reset along with the rest of the state.
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_LSB_FIRST;
      end else begin
         // NOTE: non-blocking assignments for all state so every flop sees
         // the pre-edge values regardless of statement order.
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign word = shreg_d;
   assign cnt  = cnt_q;

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
// Serial-in/parallel-out receiver. Collects a framed serial bit stream
// (MSB- or LSB-first, chosen per word) into WIDTH-bit words and presents each
// word in a one-entry output buffer with a valid/ready handshake. A word that
// completes while the buffer is full and not being drained is dropped and
// raises the sticky overrun flag.
//
// Build option
//   SIPO_PARITY_CHECK_EN : when defined, each word is followed by one even
//                          parity bit; par_err reports a mismatch alongside
//                          dout. When undefined, par_err is tied 0.
//
// Parameters
//   WIDTH  data bits per word (>= 2)
//   CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   sen         in   1      serial bit strobe; sdata sampled only when sen=1
//   sdata       in   1      serial data bit
//   sframe      in   1      with sen, marks the first bit of a word (resyncs)
//   msb_first   in   1      direction for the word being started
//   dout        out  WIDTH  received word
//   dout_valid  out  1      output buffer holds a word
//   dout_ready  in   1      consumer accepts (transfer on valid & ready)
//   ovr_clr     in   1      clears overrun
//   overrun     out  1      sticky: a completed word was dropped
//   busy        out  1      mid-word (registered state != IDLE)
//   par_err     out  1      parity mismatch of the word in dout
// -----------------------------------------------------------------------------
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sen,
   input  logic             sdata,
   input  logic             sframe,
   input  logic             msb_first,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   input  logic             ovr_clr,
   output logic             overrun,
   output logic             busy,
   output logic             par_err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dout_q,  dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q,   ovr_d;

   logic             start;      // framed bit: begins a word in any state
   logic             shift_en;   // ordinary data bit of the current word
   logic             last_bit;   // shift_en landing the WIDTH-th data bit
   logic             word_done;  // a complete word is offered to the buffer
   logic             drop;       // offered word lost to a full buffer
   logic             word_perr;  // parity verdict for the offered word
   logic [WIDTH-1:0] word;
   logic [CNT_W-1:0] cnt;

   // --------------------------------------------------------------------------
   // Bit qualification
   // --------------------------------------------------------------------------
   assign start    = sen & sframe;
   assign shift_en = sen & ~sframe & (state_q == ST_SHIFT);
   assign last_bit = shift_en & (cnt == CNT_W'(WIDTH - 1));

`ifdef SIPO_PARITY_CHECK_EN
   // The parity bit is not shifted; shreg already holds the full word, so
   // the core's word output is the held value during the PARITY cycle.
   assign word_done = sen & ~sframe & (state_q == ST_PARITY);
   assign word_perr = parity_mismatch(^word, sdata);
`else
   assign word_done = last_bit;
   assign word_perr = 1'b0;
`endif

   sipo_shift_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .sen   (shift_en),
      .sdata (sdata),
      .start (start),
      .dir   (msb_first),
      .word  (word),
      .cnt   (cnt)
   );

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_SHIFT;
      end else if (last_bit) begin
`ifdef SIPO_PARITY_CHECK_EN
         state_d = ST_PARITY;
`else
         state_d = ST_IDLE;
`endif
      end else if (word_done) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Output buffer and overrun
   // --------------------------------------------------------------------------
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      drop    = 1'b0;
      if (word_done) begin
         // A word finishing in the handshake cycle replaces the one leaving,
         // so back-to-back words need no idle gap.
         if (!valid_q || dout_ready) begin
            dout_d  = word;
            valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
      // A drop in the same cycle as ovr_clr must leave the flag set.
      ovr_d = drop | (ovr_q & ~ovr_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef SIPO_PARITY_CHECK_EN
   logic perr_q, perr_d;

   always_comb begin
      perr_d = perr_q;
      if (word_done && (!valid_q || dout_ready)) begin
         perr_d = word_perr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign par_err = perr_q;
`else
   assign par_err = word_perr;
`endif

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
// Directed scenarios with literal expectations, then a randomized stream.
// A bit-queue model of the receiver predicts every output; one process
// compares DUT and model on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;
`ifdef SIPO_PARITY_CHECK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             sen;
   logic             sdata;
   logic             sframe;
   logic             msb_first;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             ovr_clr;
   logic             overrun;
   logic             busy;
   logic             par_err;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // model state
   bit               m_bits[$];
   logic [WIDTH-1:0] m_word;
   bit               m_dir;
   bit               m_active;
   bit               m_par_phase;
   logic [WIDTH-1:0] m_dout;
   bit               m_valid;
   bit               m_ovr;
   bit               m_perr;

   sipo_deserializer #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sen        (sen),
      .sdata      (sdata),
      .sframe     (sframe),
      .msb_first  (msb_first),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .ovr_clr    (ovr_clr),
      .overrun    (overrun),
      .busy       (busy),
      .par_err    (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_word      = '0;
      m_dir       = 1'b0;
      m_active    = 1'b0;
      m_par_phase = 1'b0;
      m_dout      = '0;
      m_valid     = 1'b0;
      m_ovr       = 1'b0;
      m_perr      = 1'b0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      bit               done;
      bit               drop;
      bit               pe;
      logic [WIDTH-1:0] w;
      done = 1'b0;
      drop = 1'b0;
      pe   = 1'b0;
      w    = m_word;
      if (sen && sframe) begin
         m_bits.delete();
         m_bits.push_back(sdata);
         m_dir       = msb_first;
         m_active    = 1'b1;
         m_par_phase = 1'b0;
      end else if (sen && m_active) begin
         if (m_par_phase) begin
            done        = 1'b1;
            pe          = (^m_word) ^ sdata;
            m_active    = 1'b0;
            m_par_phase = 1'b0;
         end else begin
            m_bits.push_back(sdata);
            if (m_bits.size() == WIDTH) begin
               // i-th received bit goes to position WIDTH-1-i (MSB first) or i
               for (int i = 0; i < WIDTH; i++) begin
                  if (m_dir) w[WIDTH-1-i] = m_bits[i];
                  else       w[i]         = m_bits[i];
               end
               m_word = w;
               m_bits.delete();
               if (PAR) begin
                  m_par_phase = 1'b1;
               end else begin
                  done     = 1'b1;
                  m_active = 1'b0;
               end
            end
         end
      end
      if (done) begin
         if (!m_valid || dout_ready) begin
            m_dout  = m_word;
            m_valid = 1'b1;
            m_perr  = pe;
         end else begin
            drop = 1'b1;
         end
      end else if (m_valid && dout_ready) begin
         m_valid = 1'b0;
      end
      m_ovr = drop || (m_ovr && !ovr_clr);
   endtask

   // Drive one cycle of inputs; returns 1 time unit after the sampling edge
   // with the model already advanced past that edge.
   task automatic apply(input logic s_en, input logic s_d, input logic s_fr,
                        input logic msb, input logic rdy, input logic clr);
      sen        = s_en;
      sdata      = s_d;
      sframe     = s_fr;
      msb_first  = msb;
      dout_ready = rdy;
      ovr_clr    = clr;
      @(posedge clk);
      #1;
      model_step();
   endtask

   // Send seq[WIDTH-1] first. rdy applies to all cycles but the final bit,
   // which uses rdy_last. gap idle cycles (with msb_first toggled and random
   // sframe/sdata) separate the bits. With parity built in, an even parity
   // bit (inverted when pflip=1) follows the data.
   task automatic send_seq(input logic [WIDTH-1:0] seq, input logic msb, input logic rdy,
                           input logic rdy_last, input int gap, input logic pflip);
      for (int i = 0; i < WIDTH; i++) begin
         apply(1'b1, seq[WIDTH-1-i], (i == 0), msb,
               ((i == WIDTH-1) && !PAR) ? rdy_last : rdy, 1'b0);
         if (i < WIDTH-1 || PAR) begin
            repeat (gap) apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               ~msb, rdy, 1'b0);
         end
      end
      if (PAR) apply(1'b1, (^seq) ^ pflip, 1'b0, msb, rdy_last, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      apply(1'b0, 1'b0, 1'b0, 1'b1, rdy, 1'b0);
   endtask

   // Single compare process against the model.
   always @(negedge clk) begin
      if (chk_on && !rst) begin
         check("cmp_dout",    32'(dout),       32'(m_dout));
         check("cmp_valid",   32'(dout_valid), 32'(m_valid));
         check("cmp_overrun", 32'(overrun),    32'(m_ovr));
         check("cmp_busy",    32'(busy),       32'(m_active));
         if (m_valid || !PAR) check("cmp_par_err", 32'(par_err), 32'(m_perr));
      end
   end

   initial begin
      rst        = 1'b1;
      sen        = 1'b0;
      sdata      = 1'b0;
      sframe     = 1'b0;
      msb_first  = 1'b1;
      dout_ready = 1'b0;
      ovr_clr    = 1'b0;
      model_reset();
      #12;
      check("rst_dout",    32'(dout),       32'h0);
      check("rst_valid",   32'(dout_valid), 32'h0);
      check("rst_overrun", 32'(overrun),    32'h0);
      check("rst_busy",    32'(busy),       32'h0);
      check("rst_par_err", 32'(par_err),    32'h0);
      rst    = 1'b0;
      chk_on = 1'b1;

      // 1: MSB first, bits 1,0,1,1, ready high
      send_seq(4'b1011, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      check("t1_dout",  32'(dout),       32'hB);
      check("t1_valid", 32'(dout_valid), 32'h1);
      idle(1'b1);
      check("t1_valid_drop", 32'(dout_valid), 32'h0);

      // 2: LSB first, same bits, 3-cycle gaps
      send_seq(4'b1011, 1'b0, 1'b1, 1'b1, 3, 1'b0);
      check("t2_dout",  32'(dout),       32'hD);
      check("t2_valid", 32'(dout_valid), 32'h1);
      idle(1'b1);

      // 3: overrun with ready low, clear, then drain
      send_seq(4'hA, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("t3_dout_a", 32'(dout), 32'hA);
      send_seq(4'h5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("t3_dout_kept", 32'(dout),       32'hA);
      check("t3_overrun",   32'(overrun),    32'h1);
      check("t3_valid",     32'(dout_valid), 32'h1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("t3_ovr_clr", 32'(overrun), 32'h0);
      idle(1'b1);
      check("t3_drain", 32'(dout_valid), 32'h0);

      // 4: back-to-back, word 2 completes in the handshake cycle of word 1
      send_seq(4'h3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("t4_dout_1", 32'(dout), 32'h3);
      send_seq(4'hC, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      check("t4_dout_2",  32'(dout),       32'hC);
      check("t4_valid",   32'(dout_valid), 32'h1);
      check("t4_overrun", 32'(overrun),    32'h0);
      idle(1'b1);

      // 5: resync after two bits
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("t5_busy",  32'(busy),       32'h1);
      check("t5_valid", 32'(dout_valid), 32'h0);
      send_seq(4'b0110, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      check("t5_dout", 32'(dout), 32'h6);
      idle(1'b1);
      check("t5_single", 32'(dout_valid), 32'h0);

      // 6: asynchronous reset mid-word with valid and overrun set
      send_seq(4'hF, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      send_seq(4'hE, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("t6_dout",    32'(dout),       32'h0);
      check("t6_valid",   32'(dout_valid), 32'h0);
      check("t6_overrun", 32'(overrun),    32'h0);
      check("t6_busy",    32'(busy),       32'h0);
      check("t6_par_err", 32'(par_err),    32'h0);
      model_reset();
      rst = 1'b0;
      send_seq(4'h9, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      check("t6_dout_9", 32'(dout), 32'h9);
`ifdef SIPO_PARITY_CHECK_EN
      check("t6_par_ok", 32'(par_err), 32'h0);
      send_seq(4'h9, 1'b1, 1'b1, 1'b1, 0, 1'b1);
      check("t6_par_bad_dout", 32'(dout),    32'h9);
      check("t6_par_bad",      32'(par_err), 32'h1);
`endif
      idle(1'b1);

      // Randomized stream
      repeat (4000) begin
         apply(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 19) == 0));
      end
      idle(1'b1);
      idle(1'b1);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
